vending_controller: RTL and testbench
=====================================

Name: vending_controller

Overview:
Top-level sequencer for the vending machine datapath. Accumulates inserted coin value into a balance register, evaluates item selections against per-item prices, and runs an inactivity timer. On timeout or a user return request, it hands the balance to coin_dispenser via a trigger. It then tracks the coins the dispenser actually emits until the balance reaches zero.

Parameters:
kNumItems, 4, number of selectable items
kItemPrice0..3, 400/500/1000/2000, price of each item
kCoinValue0..2, 100/500/1000, value of each coin type (index = coin bit)
kWaitTime, 100, inactivity cycles before automatic change return
kMaxBalance, 100000, balance ceiling; must be < 2^kTotalBits

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
i_input_coin  in  kNumCoins  one bit per inserted coin this cycle; multiple bits allowed
i_select_item  in  kNumItems  item request bits
i_trigger_return  in  1  user change-return request, level-sampled
i_return_coin_fb  in  kNumCoins  coins emitted by coin_dispenser this cycle (its o_return_coin)
o_balance  out  kTotalBits  current credit; drives coin_dispenser balance
o_trigger_return  out  1  one-cycle pulse to coin_dispenser i_trigger_return
o_available_item  out  kNumItems  bit i = 1 iff kItemPriceI <= o_balance and state is CREDIT
o_output_item  out  kNumItems  one-hot pulse, one cycle, item dispensed
o_wait_time  out  kTotalBits  remaining inactivity cycles
o_busy  out  1  high in RETURN state
o_error  out  1  sticky: dispenser returned more value than balance

Behaviour:
- Reset values, asynchronous: state=IDLE; o_balance=0; o_wait_time=kWaitTime; o_trigger_return=0; o_output_item=0; o_busy=0; o_error=0.
- All outputs are registered. o_available_item is combinational from the registered balance and state.
- States:
  - IDLE: balance 0.
  - CREDIT: balance > 0, accepting input.
  - RETURN: change being paid out.
- Coin insert (IDLE/CREDIT):
  - sum = Σ kCoinValueN over asserted i_input_coin bits.
  - If balance+sum <= kMaxBalance: the whole sum is accepted, wait_time reloads to kWaitTime, and the state becomes CREDIT.
  - Otherwise the entire cycle's coins are rejected and the balance is unchanged.
  - Coins are ignored in RETURN.
- Select (CREDIT only):
  - The lowest-index asserted bit wins; other bits are ignored that cycle.
  - If price <= balance at the clock edge: the balance is decremented by the price, o_output_item pulses that bit next cycle, and wait_time reloads.
  - Otherwise the request is ignored with no side effects.
- Coin and select in the same cycle: the select is checked against the pre-insert balance. Next balance = balance - price (if granted) + sum (if accepted). The overflow check uses the post-deduction value.
- Timer: decrements by 1 per cycle in CREDIT when no coin is accepted and no item is dispensed. It saturates at 0 and is held at kWaitTime in IDLE.
- Return entry: from CREDIT, when i_trigger_return=1 or wait_time==0:
  - o_trigger_return=1 for exactly one cycle; state=RETURN; o_busy=1.
  - A return trigger in the same cycle as a select takes precedence; the select is ignored.
  - A trigger in IDLE is ignored.
- RETURN state:
  - Each cycle, fb = Σ kCoinValueN over i_return_coin_fb bits.
  - If fb <= balance, balance -= fb.
  - If fb > balance, balance=0 and o_error is set.
  - When the balance reaches 0 (registered value), go to IDLE next cycle, with o_busy=0 and wait_time=kWaitTime.
  - i_trigger_return, coins and selects are ignored in RETURN.
- Balance reaching 0 via purchase in CREDIT returns the state to IDLE without any return pulse.
- Reset mid-RETURN: the balance is lost (cleared) and the dispenser trigger is dropped. Resetting the dispenser is the system's responsibility.

Decomposition:
- vending_machine_def.v holds:
  - kTotalBits, kNumCoins, kNumItems
  - coin value and item price constants
  - state encodings (IDLE=2'd0, CREDIT=2'd1, RETURN=2'd2)
- One sub-module is natural: coin_value_sum, a combinational Σ over a coin bit vector. It is instanced twice, once for i_input_coin and once for i_return_coin_fb.
- The FSM, balance register and timer stay in vending_controller.

Test Plan:
- Reset, then insert 1000 (bit2) -> next cycle o_balance=1000, state CREDIT, o_available_item=4'b0111, o_wait_time=100.
- Balance 1000, select 4'b1010 -> item1 granted: o_output_item=4'b0010 pulse, o_balance=500, o_available_item=4'b0011.
- Balance 500, simultaneous insert 100 and select item2 (price 1000) -> select ignored; o_balance=600, o_output_item=0.
- Balance 1600, idle 100 cycles -> o_wait_time hits 0, o_trigger_return pulses once. Feed fb 3'b111 -> o_balance=0, then IDLE, o_busy=0.
- Balance 99800, insert 500 -> rejected, o_balance stays 99800. Insert 100 -> o_balance=99900.
- RETURN with balance 100, feed fb 3'b010 -> o_balance=0, o_error=1 (sticky until reset). Assert reset mid-RETURN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/vending_controller_pkg.sv
// Shared constants and state encoding for the vending machine controller.
// Coin and price tables are packed so index N matches coin bit / item bit N.
package vending_controller_pkg;
  localparam int kTotalBits  = 17;
  localparam int kNumCoins   = 3;
  localparam int kNumItems   = 4;
  localparam int kWaitTime   = 100;
  localparam int kMaxBalance = 100000;

  localparam logic [kNumCoins-1:0][kTotalBits-1:0] kCoinValue =
    {kTotalBits'(1000), kTotalBits'(500), kTotalBits'(100)};
  localparam logic [kNumItems-1:0][kTotalBits-1:0] kItemPrice =
    {kTotalBits'(2000), kTotalBits'(1000), kTotalBits'(500), kTotalBits'(400)};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    RETURN = 2'd2
  } state_t;
endpackage

// File: rtl/coin_value_sum.sv
// Combinational total value of a coin bit vector (one bit per coin type).
module coin_value_sum
  import vending_controller_pkg::*;
(
  input  logic [kNumCoins-1:0]  i_coin,
  output logic [kTotalBits-1:0] o_sum
);
  always_comb begin
    o_sum = '0;
    for (int i = 0; i < kNumCoins; i++)
      if (i_coin[i]) o_sum = o_sum + kCoinValue[i];
  end
endmodule

// File: rtl/vending_controller.sv
// Vending sequencer: balance accumulation, item grants, inactivity timer and
// change-return handoff to the coin dispenser.
module vending_controller
  import vending_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  input  logic [kNumCoins-1:0]  i_return_coin_fb,
  output logic [kTotalBits-1:0] o_balance,
  output logic                  o_trigger_return,
  output logic [kNumItems-1:0]  o_available_item,
  output logic [kNumItems-1:0]  o_output_item,
  output logic [kTotalBits-1:0] o_wait_time,
  output logic                  o_busy,
  output logic                  o_error
);
  localparam logic [kTotalBits-1:0] kWait = kTotalBits'(kWaitTime);
  localparam logic [kTotalBits:0]   kMax  = (kTotalBits+1)'(kMaxBalance);

  state_t                r_state;
  logic [kTotalBits-1:0] r_balance, r_wait;
  logic                  r_trig, r_busy, r_error;
  logic [kNumItems-1:0]  r_out_item;

  logic [kTotalBits-1:0] w_coin_sum, w_fb_sum, w_price, w_after_sel, w_next_bal, w_wait_dec;
  logic [kTotalBits:0]   w_bal_ext;
  logic [kNumItems-1:0]  w_sel_onehot;
  logic                  w_sel_hit, w_ret_entry, w_grant, w_accept;

  coin_value_sum u_coin_sum (.i_coin(i_input_coin),     .o_sum(w_coin_sum));
  coin_value_sum u_fb_sum   (.i_coin(i_return_coin_fb), .o_sum(w_fb_sum));

  // Descending scan so the lowest asserted index is the last (winning) write.
  always_comb begin
    w_sel_hit    = 1'b0;
    w_sel_onehot = '0;
    w_price      = '0;
    for (int i = kNumItems-1; i >= 0; i--)
      if (i_select_item[i]) begin
        w_sel_hit       = 1'b1;
        w_sel_onehot    = '0;
        w_sel_onehot[i] = 1'b1;
        w_price         = kItemPrice[i];
      end
  end

  // Return entry freezes the balance: coins and selects that cycle are dropped.
  assign w_ret_entry = (r_state == CREDIT) && (i_trigger_return || (r_wait == '0));
  assign w_grant     = (r_state == CREDIT) && !w_ret_entry && w_sel_hit && (w_price <= r_balance);
  assign w_after_sel = r_balance - (w_grant ? w_price : '0);
  assign w_bal_ext   = {1'b0, w_after_sel} + {1'b0, w_coin_sum};
  assign w_accept    = (r_state != RETURN) && !w_ret_entry && (|i_input_coin) && (w_bal_ext <= kMax);
  assign w_next_bal  = w_accept ? w_bal_ext[kTotalBits-1:0] : w_after_sel;
  assign w_wait_dec  = (r_wait == '0) ? '0 : r_wait - 1'b1;

  always_comb begin
    o_available_item = '0;
    for (int i = 0; i < kNumItems; i++)
      o_available_item[i] = (r_state == CREDIT) && (kItemPrice[i] <= r_balance);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_balance  <= '0;
      r_wait     <= kWait;
      r_trig     <= 1'b0;
      r_out_item <= '0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        RETURN: begin
          r_trig     <= 1'b0;
          r_out_item <= '0;
          if (w_fb_sum > r_balance) begin
            r_balance <= '0;
            r_error   <= 1'b1;
          end else begin
            r_balance <= r_balance - w_fb_sum;
          end
          if (r_balance == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_wait  <= kWait;
          end
        end
        default: begin
          if (w_ret_entry) begin
            r_state    <= RETURN;
            r_busy     <= 1'b1;
            r_trig     <= 1'b1;
            r_out_item <= '0;
          end else begin
            r_trig     <= 1'b0;
            r_balance  <= w_next_bal;
            r_out_item <= w_grant ? w_sel_onehot : '0;
            if (w_next_bal == '0) begin
              r_state <= IDLE;
              r_wait  <= kWait;
            end else begin
              r_state <= CREDIT;
              r_wait  <= (w_accept || w_grant || r_state != CREDIT) ? kWait : w_wait_dec;
            end
          end
        end
      endcase
    end
  end

  assign o_balance        = r_balance;
  assign o_trigger_return = r_trig;
  assign o_output_item    = r_out_item;
  assign o_wait_time      = r_wait;
  assign o_busy           = r_busy;
  assign o_error          = r_error;
endmodule

// File: tb/tb_vending_controller.sv
// Directed plus randomized bench for vending_controller against a behavioural model.
module tb_vending_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  coin, fb;
  logic [3:0]  sel;
  logic        trig_in;
  logic [16:0] o_balance, o_wait_time;
  logic        o_trigger_return, o_busy, o_error;
  logic [3:0]  o_available_item, o_output_item;

  vending_controller dut (
    .clk(clk), .reset(reset),
    .i_input_coin(coin), .i_select_item(sel),
    .i_trigger_return(trig_in), .i_return_coin_fb(fb),
    .o_balance(o_balance), .o_trigger_return(o_trigger_return),
    .o_available_item(o_available_item), .o_output_item(o_output_item),
    .o_wait_time(o_wait_time), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk = ~clk;

  localparam int W = 100;
  localparam int MAXB = 100000;
  int PRICE [4] = '{400, 500, 1000, 2000};
  int COINV [3] = '{100, 500, 1000};

  int n_tests = 0, n_fail = 0;
  // model: mode 0 idle, 1 credit, 2 paying change
  int m_bal, m_wait, m_mode;
  bit m_trig, m_busy, m_err;
  logic [3:0] m_item;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int value_of(input logic [2:0] c);
    int s = 0;
    for (int i = 0; i < 3; i++) if (c[i]) s += COINV[i];
    return s;
  endfunction

  function automatic logic [3:0] m_avail();
    logic [3:0] a = '0;
    for (int i = 0; i < 4; i++) a[i] = (m_mode == 1) && (PRICE[i] <= m_bal);
    return a;
  endfunction

  task automatic model_reset();
    m_bal = 0; m_wait = W; m_mode = 0;
    m_trig = 0; m_busy = 0; m_err = 0; m_item = '0;
  endtask

  task automatic model_step();
    int cs, fs, price, idx, after;
    bit grant, accept;
    cs = value_of(coin);
    fs = value_of(fb);
    if (m_mode == 2) begin
      m_trig = 0; m_item = '0;
      if (m_bal == 0) begin m_mode = 0; m_busy = 0; m_wait = W; end
      if (fs > m_bal) begin m_bal = 0; m_err = 1; end
      else m_bal = m_bal - fs;
    end else if (m_mode == 1 && (trig_in || m_wait == 0)) begin
      m_mode = 2; m_busy = 1; m_trig = 1; m_item = '0;
    end else begin
      grant = 0; idx = 0; price = 0;
      if (m_mode == 1 && sel != 0) begin
        for (int i = 3; i >= 0; i--) if (sel[i]) idx = i;
        if (PRICE[idx] <= m_bal) begin grant = 1; price = PRICE[idx]; end
      end
      after = m_bal - price;
      accept = (cs > 0) && (after + cs <= MAXB);
      m_item = grant ? 4'(1 << idx) : 4'b0;
      m_trig = 0;
      if (accept || grant || m_mode != 1) m_wait = W;
      else m_wait = (m_wait > 0) ? m_wait - 1 : 0;
      m_bal = after + (accept ? cs : 0);
      if (m_bal == 0) begin m_mode = 0; m_wait = W; end
      else m_mode = 1;
    end
  endtask

  task automatic check_all();
    chk("balance", o_balance, m_bal);
    chk("wait_time", o_wait_time, m_wait);
    chk("trigger", o_trigger_return, m_trig);
    chk("out_item", o_output_item, m_item);
    chk("avail", o_available_item, m_avail());
    chk("busy", o_busy, m_busy);
    chk("error", o_error, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    int seen;
    reset = 1'b1; coin = '0; fb = '0; sel = '0; trig_in = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("rst_wait", o_wait_time, 100);
    reset = 1'b0;

    // insert 1000
    coin = 3'b100; tick(); coin = '0;
    chk("t1_bal", o_balance, 1000);
    chk("t1_avail", o_available_item, 4'b0111);
    chk("t1_wait", o_wait_time, 100);

    // select 1010 -> item1
    sel = 4'b1010; tick(); sel = '0;
    chk("t2_item", o_output_item, 4'b0010);
    chk("t2_bal", o_balance, 500);
    chk("t2_avail", o_available_item, 4'b0011);

    // coin 100 with unaffordable item2
    coin = 3'b001; sel = 4'b0100; tick(); coin = '0; sel = '0;
    chk("t3_bal", o_balance, 600);
    chk("t3_item", o_output_item, 4'b0000);

    // reach 1600 then time out
    coin = 3'b100; tick(); coin = '0;
    chk("t4_bal", o_balance, 1600);
    seen = 0;
    for (int i = 0; i < 150 && !o_busy; i++) begin
      tick();
      if (o_trigger_return) seen++;
    end
    chk("t4_trig_seen", seen, 1);
    tick();
    chk("t4_trig_once", o_trigger_return, 0);
    fb = 3'b111; tick(); fb = '0;
    chk("t4_drained", o_balance, 0);
    tick();
    chk("t4_idle_busy", o_busy, 0);
    chk("t4_idle_wait", o_wait_time, 100);

    // overflow boundary
    for (int i = 0; i < 62; i++) begin coin = 3'b111; tick(); end
    coin = 3'b011; tick();
    chk("t5_bal", o_balance, 99800);
    coin = 3'b010; tick();
    chk("t5_reject", o_balance, 99800);
    coin = 3'b001; tick();
    chk("t5_accept", o_balance, 99900);
    coin = 3'b001; tick(); coin = '0;
    chk("t5_ceiling", o_balance, 100000);
    apply_reset();

    // over-return error, sticky, then reset mid-return
    coin = 3'b001; tick(); coin = '0;
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    chk("t6_trig", o_trigger_return, 1);
    fb = 3'b010; tick(); fb = '0;
    chk("t6_bal", o_balance, 0);
    chk("t6_err", o_error, 1);
    tick();
    chk("t6_err_sticky", o_error, 1);
    coin = 3'b001; tick(); coin = '0;
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    chk("t6_busy", o_busy, 1);
    apply_reset();
    chk("t6_rst_err", o_error, 0);
    chk("t6_rst_busy", o_busy, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      coin    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
      sel     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      trig_in = ($urandom_range(0, 39) == 0);
      fb      = (m_mode == 2 && $urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b0;
      tick();
      if ($urandom_range(0, 999) == 0) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
